vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 timing constants in vgachargen_pkg.
- Produces pixel/line counters, hsync/vsync with configurable polarity, display-enable and frame/line strobes, gated by a programmable pixel-clock divider.
- Sits between the system clock and the character-map/bitmap fetch pipeline of apb_vgachargen.
- Any VESA-style mode is selected by parameters.

Parameters:
- HD, 640, horizontal display pixels
- HF, 16, horizontal front porch
- HR, 96, horizontal sync width
- HB, 48, horizontal back porch
- VD, 480, vertical display lines
- VF, 10, vertical front porch
- VR, 2, vertical sync width
- VB, 33, vertical back porch
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CLK_DIV, 4, system clocks per pixel; legal values are 1 or greater

Ports:
- clk_i, in, 1, system clock
- arstn_i, in, 1, asynchronous active-low reset
- en_i, in, 1, run enable
- pix_tick_o, out, 1, one-clk pulse per pixel (clock enable for downstream logic)
- hcount_o, out, $clog2(HD+HF+HR+HB), current pixel column
- vcount_o, out, $clog2(VD+VF+VR+VB), current line
- de_o, out, 1, display enable (hcount<HD and vcount<VD)
- hsync_o, out, 1, horizontal sync
- vsync_o, out, 1, vertical sync
- line_start_o, out, 1, pulse on tick where hcount becomes 0
- frame_start_o, out, 1, pulse on tick where (hcount,vcount) becomes (0,0)

Behaviour:
- HTOTAL=HD+HF+HR+HB, VTOTAL=VD+VF+VR+VB. Elaboration error if any timing parameter is 0 or CLK_DIV is 0.
- Reset (arstn_i low, async): div counter=0, hcount/vcount=0, de_o=0, pix_tick_o=0, line_start_o=0, frame_start_o=0, hsync_o=!HSYNC_POL, vsync_o=!VSYNC_POL.
- Divider:
  - counts 0..CLK_DIV-1 while en_i=1; tick when div==CLK_DIV-1.
  - pix_tick_o is a registered tick, so it is high for exactly 1 clk in every CLK_DIV clks.
  - CLK_DIV=1 means pix_tick_o is constantly high while running.
- Counters advance only on a tick:
  - hcount wraps HTOTAL-1 to 0.
  - On that wrap, vcount increments and wraps VTOTAL-1 to 0.
- Output registers:
  - hcount_o, vcount_o, de_o, hsync_o, vsync_o and the strobes update on the same clk edge as pix_tick_o rises.
  - They describe the pixel whose tick is being issued, so all outputs are mutually aligned with 0 skew.
- Regions (inclusive-exclusive):
  - display [0,HD), front porch [HD,HD+HF), sync [HD+HF,HD+HF+HR), back porch [HD+HF+HR,HTOTAL).
  - Vertical regions are analogous.
- hsync_o=HSYNC_POL while hcount is in the horizontal sync region, else !HSYNC_POL. vsync_o is the same, keyed on vcount only and independent of hcount.
- de_o=1 iff hcount<HD and vcount<VD.
- line_start_o and frame_start_o are high only on the tick clk for position hcount=0 (and vcount=0 for frame_start_o).
- First-tick rule:
  - After reset release with en_i=1, the first tick occurs at clk CLK_DIV and presents (0,0) with frame_start_o=1 and line_start_o=1.
  - Counters are pre-armed so the first presented position is (0,0), not (1,0).
- en_i deassert, mid-frame or any time:
  - the next clk returns every output and counter to its reset values (synchronous soft reset);
  - re-assert restarts per the first-tick rule.
- Between ticks, all outputs hold except pix_tick_o and the strobes, which are 0.
- No combinational path from any input to any output.

Decomposition:
- Extend vgachargen_pkg with a vga_timing_t struct (hd,hf,hr,hb,vd,vf,vr,vb) and constants VGA_640x480 and VGA_800x600, plus the derived HTOTAL/VTOTAL helper functions.
- One natural sub-module: vga_axis_counter, a single-axis counter plus region decoder (count, wrap, sync, active). It is instantiated twice, with the horizontal wrap acting as the vertical increment enable.

Test Plan:
- Small mode (HD=4,HF=1,HR=2,HB=1,VD=3,VF=1,VR=1,VB=1,CLK_DIV=2), en_i=1 after reset -> pix_tick_o every 2nd clk; hcount sequence 0..7 wraps; hsync_o low exactly at hcount 5,6; de_o high for hcount 0..3 on vcount 0..2.
- Same mode, run 2 frames -> frame_start_o pulses exactly 2 times, 48 ticks apart (8x6); line_start_o pulses 12 times; vsync_o low exactly during vcount=4.
- HSYNC_POL=1, VSYNC_POL=1 -> hsync_o/vsync_o idle low after reset, high only in the sync regions.
- Drop en_i at hcount=3, vcount=1 -> next clk all outputs at reset values. Re-raise en_i -> first tick after 2 clks shows (0,0) with frame_start_o=1.
- Assert arstn_i low asynchronously mid-line (between clk edges) -> outputs reach reset values immediately, without waiting for a clk edge.
- Default 640x480, CLK_DIV=1 -> 800 ticks per line, 525 lines per frame, de_o high for 640x480=307200 ticks per frame.

Source files
------------

// File: rtl/vgachargen_pkg.sv
// Shared VGA mode descriptions: per-axis timing struct, standard modes and
// helpers that derive the full line/frame lengths from a mode.
package vgachargen_pkg;

    typedef struct packed {
        int unsigned hd;
        int unsigned hf;
        int unsigned hr;
        int unsigned hb;
        int unsigned vd;
        int unsigned vf;
        int unsigned vr;
        int unsigned vb;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{hd: 640, hf: 16, hr: 96,  hb: 48,
                                            vd: 480, vf: 10, vr: 2,   vb: 33};
    localparam vga_timing_t VGA_800x600 = '{hd: 800, hf: 40, hr: 128, hb: 88,
                                            vd: 600, vf: 1,  vr: 4,   vb: 23};

    function automatic int unsigned vga_htotal(input vga_timing_t t);
        return t.hd + t.hf + t.hr + t.hb;
    endfunction

    function automatic int unsigned vga_vtotal(input vga_timing_t t);
        return t.vd + t.vf + t.vr + t.vb;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// Single raster axis: position counter plus registered region decode for the
// position presented on each step (count, sync level, active, zero strobe).
module vga_axis_counter #(
    parameter int unsigned ACTIVE   = 640,
    parameter int unsigned FRONT    = 16,
    parameter int unsigned SYNC     = 96,
    parameter int unsigned BACK     = 48,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned W        = $clog2(ACTIVE + FRONT + SYNC + BACK)
) (
    input  logic         clk_i,
    input  logic         arstn_i,
    input  logic         clr_i,
    input  logic         step_i,
    input  logic         adv_i,
    output logic [W-1:0] count_o,
    output logic         sync_o,
    output logic         active_o,
    output logic         zero_o,
    output logic         last_o
);

    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FRONT);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FRONT + SYNC);
    localparam logic [W-1:0] LAST     = W'(ACTIVE + FRONT + SYNC + BACK - 1);
    localparam logic         SYNC_ON  = SYNC_POL;
    localparam logic         SYNC_OFF = ~SYNC_POL;

    // cnt_q is the position to be presented on the next step (pre-armed).
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] count_q, count_d;
    logic         sync_q, sync_d;
    logic         active_q, active_d;
    logic         zero_q, zero_d;

    assign last_o = (cnt_q == LAST);

    always_comb begin
        cnt_d    = cnt_q;
        count_d  = count_q;
        sync_d   = sync_q;
        active_d = active_q;
        zero_d   = 1'b0;
        if (clr_i) begin
            cnt_d    = '0;
            count_d  = '0;
            sync_d   = SYNC_OFF;
            active_d = 1'b0;
        end else if (step_i) begin
            count_d  = cnt_q;
            sync_d   = ((cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END)) ? SYNC_ON : SYNC_OFF;
            active_d = (cnt_q < ACT_END);
            zero_d   = (cnt_q == '0);
            if (adv_i) begin
                cnt_d = last_o ? '0 : cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt_q    <= '0;
            count_q  <= '0;
            sync_q   <= SYNC_OFF;
            active_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            sync_q   <= sync_d;
            active_q <= active_d;
            zero_q   <= zero_d;
        end
    end

    assign count_o  = count_q;
    assign sync_o   = sync_q;
    assign active_o = active_q;
    assign zero_o   = zero_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider driving a
// horizontal axis counter whose wrap steps the vertical axis counter.
module vga_timing_gen
    import vgachargen_pkg::*;
#(
    parameter int unsigned HD        = 640,
    parameter int unsigned HF        = 16,
    parameter int unsigned HR        = 96,
    parameter int unsigned HB        = 48,
    parameter int unsigned VD        = 480,
    parameter int unsigned VF        = 10,
    parameter int unsigned VR        = 2,
    parameter int unsigned VB        = 33,
    parameter int unsigned HSYNC_POL = 0,
    parameter int unsigned VSYNC_POL = 0,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                            clk_i,
    input  logic                            arstn_i,
    input  logic                            en_i,
    output logic                            pix_tick_o,
    output logic [$clog2(HD+HF+HR+HB)-1:0]  hcount_o,
    output logic [$clog2(VD+VF+VR+VB)-1:0]  vcount_o,
    output logic                            de_o,
    output logic                            hsync_o,
    output logic                            vsync_o,
    output logic                            line_start_o,
    output logic                            frame_start_o
);

    localparam vga_timing_t MODE = '{hd: HD, hf: HF, hr: HR, hb: HB,
                                     vd: VD, vf: VF, vr: VR, vb: VB};
    localparam int unsigned HW    = $clog2(vga_htotal(MODE));
    localparam int unsigned VW    = $clog2(vga_vtotal(MODE));
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (HD == 0 || HF == 0 || HR == 0 || HB == 0 ||
        VD == 0 || VF == 0 || VR == 0 || VB == 0 || CLK_DIV == 0) begin : g_param_check
        $error("vga_timing_gen: timing parameters and CLK_DIV must be non-zero");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q, pix_tick_d;
    logic             tick;
    logic             clr;

    // Dropping en_i acts as a synchronous soft reset of the whole raster.
    assign clr = ~en_i;

    always_comb begin
        div_d = div_q;
        tick  = 1'b0;
        if (!en_i) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            tick  = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        pix_tick_d = tick;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            div_q      <= '0;
            pix_tick_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            pix_tick_q <= pix_tick_d;
        end
    end

    logic h_active, h_zero, h_last;
    logic v_active, v_zero, v_last_unused;

    vga_axis_counter #(
        .ACTIVE   (HD),
        .FRONT    (HF),
        .SYNC     (HR),
        .BACK     (HB),
        .SYNC_POL (HSYNC_POL != 0),
        .W        (HW)
    ) u_haxis (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .clr_i    (clr),
        .step_i   (tick),
        .adv_i    (tick),
        .count_o  (hcount_o),
        .sync_o   (hsync_o),
        .active_o (h_active),
        .zero_o   (h_zero),
        .last_o   (h_last)
    );

    // Vertical outputs refresh on every pixel but the line only advances on
    // the tick that presents the last column.
    vga_axis_counter #(
        .ACTIVE   (VD),
        .FRONT    (VF),
        .SYNC     (VR),
        .BACK     (VB),
        .SYNC_POL (VSYNC_POL != 0),
        .W        (VW)
    ) u_vaxis (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .clr_i    (clr),
        .step_i   (tick),
        .adv_i    (tick & h_last),
        .count_o  (vcount_o),
        .sync_o   (vsync_o),
        .active_o (v_active),
        .zero_o   (v_zero),
        .last_o   (v_last_unused)
    );

    assign pix_tick_o    = pix_tick_q;
    assign de_o          = h_active & v_active;
    assign line_start_o  = h_zero;
    assign frame_start_o = h_zero & v_zero;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 8x6 raster (both sync polarities) plus default
// 640x480 at one clock per pixel, checked with immediate assertions.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic arstn;
    logic en;

    always #5 clk = ~clk;

    logic [2:0] s_hcount, s_vcount, p_hcount, p_vcount;
    logic       s_pix, s_de, s_hs, s_vs, s_ls, s_fs;
    logic       p_pix, p_de, p_hs, p_vs, p_ls, p_fs;
    logic [9:0] b_hcount, b_vcount;
    logic       b_pix, b_de, b_hs, b_vs, b_ls, b_fs;

    vga_timing_gen #(
        .HD(4), .HF(1), .HR(2), .HB(1), .VD(3), .VF(1), .VR(1), .VB(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(2)
    ) u_small (
        .clk_i(clk), .arstn_i(arstn), .en_i(en), .pix_tick_o(s_pix),
        .hcount_o(s_hcount), .vcount_o(s_vcount), .de_o(s_de),
        .hsync_o(s_hs), .vsync_o(s_vs), .line_start_o(s_ls), .frame_start_o(s_fs)
    );

    vga_timing_gen #(
        .HD(4), .HF(1), .HR(2), .HB(1), .VD(3), .VF(1), .VR(1), .VB(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(2)
    ) u_pos (
        .clk_i(clk), .arstn_i(arstn), .en_i(en), .pix_tick_o(p_pix),
        .hcount_o(p_hcount), .vcount_o(p_vcount), .de_o(p_de),
        .hsync_o(p_hs), .vsync_o(p_vs), .line_start_o(p_ls), .frame_start_o(p_fs)
    );

    vga_timing_gen #(.CLK_DIV(1)) u_big (
        .clk_i(clk), .arstn_i(arstn), .en_i(en), .pix_tick_o(b_pix),
        .hcount_o(b_hcount), .vcount_o(b_vcount), .de_o(b_de),
        .hsync_o(b_hs), .vsync_o(b_vs), .line_start_o(b_ls), .frame_start_o(b_fs)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_small_reset(input string tag);
        chk({tag, "_pix"}, 32'(s_pix), 0);
        chk({tag, "_hcount"}, 32'(s_hcount), 0);
        chk({tag, "_vcount"}, 32'(s_vcount), 0);
        chk({tag, "_de"}, 32'(s_de), 0);
        chk({tag, "_hsync"}, 32'(s_hs), 1);
        chk({tag, "_vsync"}, 32'(s_vs), 1);
        chk({tag, "_ls"}, 32'(s_ls), 0);
        chk({tag, "_fs"}, 32'(s_fs), 0);
        chk({tag, "_p_hsync"}, 32'(p_hs), 0);
        chk({tag, "_p_vsync"}, 32'(p_vs), 0);
    endtask

    int bt, bde, bls, bfs, bhs, bvs, blast_h;

    task automatic big_sample();
        if (b_pix) bt++;
        if (b_de) bde++;
        if (b_ls) bls++;
        if (b_fs) bfs++;
        if (!b_hs) bhs++;
        if (!b_vs) bvs++;
        blast_h = 32'(b_hcount);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int eh, ev, ls_cnt, fs_cnt, fs_idx0, fs_idx1;
        bit found;

        arstn = 1'b0;
        en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_small_reset("reset");
        chk("reset_b_pix", 32'(b_pix), 0);

        // Release with en_i high: first small tick lands on the 2nd clk.
        arstn = 1'b1;
        en    = 1'b1;
        step();
        chk("first_clk1_pix", 32'(s_pix), 0);
        chk("big_first_pix", 32'(b_pix), 1);
        chk("big_first_fs", 32'(b_fs), 1);
        step();
        chk("first_tick_pix", 32'(s_pix), 1);
        chk("first_tick_fs", 32'(s_fs), 1);
        chk("first_tick_ls", 32'(s_ls), 1);

        // Two full frames of the 8x6 raster.
        eh = 0; ev = 0; ls_cnt = 0; fs_cnt = 0; fs_idx0 = -1; fs_idx1 = -1;
        for (int t = 0; t < 96; t++) begin
            chk("run_hcount", 32'(s_hcount), 32'(eh));
            chk("run_vcount", 32'(s_vcount), 32'(ev));
            chk("run_de", 32'(s_de), 32'(eh < 4 && ev < 3));
            chk("run_hsync", 32'(s_hs), 32'(!(eh == 5 || eh == 6)));
            chk("run_vsync", 32'(s_vs), 32'(ev != 4));
            chk("run_ls", 32'(s_ls), 32'(eh == 0));
            chk("run_fs", 32'(s_fs), 32'(eh == 0 && ev == 0));
            chk("run_p_hsync", 32'(p_hs), 32'(eh == 5 || eh == 6));
            chk("run_p_vsync", 32'(p_vs), 32'(ev == 4));
            if (s_ls) ls_cnt++;
            if (s_fs) begin
                if (fs_cnt == 0) fs_idx0 = t; else fs_idx1 = t;
                fs_cnt++;
            end
            step();
            chk("gap_pix", 32'(s_pix), 0);
            chk("gap_ls", 32'(s_ls), 0);
            chk("gap_fs", 32'(s_fs), 0);
            chk("gap_hold_h", 32'(s_hcount), 32'(eh));
            step();
            chk("tick_pix", 32'(s_pix), 1);
            eh++;
            if (eh == 8) begin
                eh = 0;
                ev = (ev == 5) ? 0 : ev + 1;
            end
        end
        chk("frame_start_count", 32'(fs_cnt), 2);
        chk("frame_start_spacing", 32'(fs_idx1 - fs_idx0), 48);
        chk("line_start_count", 32'(ls_cnt), 12);

        // Soft reset via en_i at (3,1).
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (s_pix && s_hcount == 3'd3 && s_vcount == 3'd1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("reach_3_1", 32'(found), 1);
        chk("at_3_1_de", 32'(s_de), 1);
        en = 1'b0;
        step();
        chk_small_reset("en_drop");
        step();
        chk("en_low_pix", 32'(s_pix), 0);
        en = 1'b1;
        step();
        chk("reen_clk1_pix", 32'(s_pix), 0);
        step();
        chk("reen_pix", 32'(s_pix), 1);
        chk("reen_hcount", 32'(s_hcount), 0);
        chk("reen_vcount", 32'(s_vcount), 0);
        chk("reen_fs", 32'(s_fs), 1);

        // Asynchronous reset between clock edges, mid-line.
        repeat (4) step();
        chk("pre_arst_hcount", 32'(s_hcount), 2);
        #3;
        arstn = 1'b0;
        #1;
        chk_small_reset("arst");
        step();
        arstn = 1'b1;

        bt = 0; bde = 0; bls = 0; bfs = 0; bhs = 0; bvs = 0; blast_h = -1;
        step();
        chk("arst_rel_clk1_pix", 32'(s_pix), 0);
        chk("big_line0_fs", 32'(b_fs), 1);
        chk("big_line0_h", 32'(b_hcount), 0);
        big_sample();
        step();
        chk("arst_rel_pix", 32'(s_pix), 1);
        chk("arst_rel_hcount", 32'(s_hcount), 0);
        chk("arst_rel_fs", 32'(s_fs), 1);
        big_sample();
        for (int c = 2; c < 800; c++) begin
            step();
            big_sample();
        end
        chk("big_ticks_per_line", 32'(bt), 800);
        chk("big_de_per_line", 32'(bde), 640);
        chk("big_hsync_active", 32'(bhs), 96);
        chk("big_vsync_line0", 32'(bvs), 0);
        chk("big_ls_count", 32'(bls), 1);
        chk("big_fs_count", 32'(bfs), 1);
        chk("big_last_h", 32'(blast_h), 799);
        step();
        chk("big_wrap_h", 32'(b_hcount), 0);
        chk("big_wrap_v", 32'(b_vcount), 1);
        chk("big_wrap_ls", 32'(b_ls), 1);
        chk("big_wrap_fs", 32'(b_fs), 0);
        chk("big_wrap_de", 32'(b_de), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
